// File: rtl/stacked_incr_reg.sv
// stacked_incr_reg: program-counter style address register.
// It supports hold, load, increment, decrement, signed-relative add and clear.
// A small LIFO return stack holds CALL/RET return addresses.
// All state updates on the falling edge of clk. rst is synchronous, active-high, and wins over ctrl.
module stacked_incr_reg #(
  parameter int             N         = 8,
  parameter int             STEP      = 1,
  parameter int             DEPTH     = 4,
  parameter bit             SAT       = 1'b0,
  parameter logic [N-1:0]   RESET_VAL = '0,
  localparam int            CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    ctrl,
  input  logic [N-1:0]  in,
  output logic [N-1:0]  out,
  output logic          wrap,
  output logic [CW-1:0] stk_count,
  output logic          stk_full,
  output logic          stk_empty,
  output logic          stk_err
);

  // Stack index width: at least one bit, even when DEPTH is 1.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_INCR   = 3'b010;
  localparam logic [2:0] OP_DECR   = 3'b011;
  localparam logic [2:0] OP_ADDREL = 3'b100;
  localparam logic [2:0] OP_CLEAR  = 3'b101;
  localparam logic [2:0] OP_CALL   = 3'b110;
  localparam logic [2:0] OP_RET    = 3'b111;

  // Arithmetic runs at N+2 bits, so every exact result fits.
  // Bit N+1 set means the result went below 0.
  // Bit N set (with bit N+1 clear) means the result went above 2^N-1.
  localparam logic [N+1:0] STEP_X = (N + 2)'(STEP);

  logic [N-1:0]  r_out;
  logic          r_wrap;
  logic [CW-1:0] r_count;
  logic          r_err;
  logic [N-1:0]  r_stack [DEPTH];

  logic [N+1:0]  w_ext_out;
  logic [N+1:0]  w_inc_x;
  logic [N+1:0]  w_dec_x;
  logic [N+1:0]  w_rel_x;
  logic [N-1:0]  w_ret_addr;
  logic [IW-1:0] w_push_idx;
  logic [IW-1:0] w_pop_idx;
  logic          w_full;
  logic          w_empty;
  logic [N-1:0]  w_nxt_out;
  logic          w_nxt_wrap;
  logic          w_push;
  logic          w_pop;
  logic          w_set_err;

  // Out of range when the exact result is negative or exceeds 2^N-1.
  function automatic logic oob(input logic [N+1:0] x);
    return x[N+1] | x[N];
  endfunction

  // Fold an exact result back into N bits.
  // SAT=0 wraps modulo 2^N. SAT=1 clamps to the nearer bound.
  function automatic logic [N-1:0] fit(input logic [N+1:0] x);
    if (!SAT)        return x[N-1:0];
    else if (x[N+1]) return '0;
    else if (x[N])   return '1;
    else             return x[N-1:0];
  endfunction

  assign w_ext_out  = {2'b00, r_out};
  assign w_inc_x    = w_ext_out + STEP_X;
  assign w_dec_x    = w_ext_out - STEP_X;
  assign w_rel_x    = w_ext_out + {{2{in[N-1]}}, in};

  // The return address is always taken modulo 2^N, even when SAT=1.
  assign w_ret_addr = w_inc_x[N-1:0];

  assign w_push_idx = r_count[IW-1:0];
  assign w_pop_idx  = IW'(r_count - CW'(1));
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);

  // Decode ctrl into the next register value, the wrap flag and the stack actions.
  always_comb begin
    w_nxt_out  = r_out;
    w_nxt_wrap = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_set_err  = 1'b0;
    case (ctrl)
      OP_HOLD:   w_nxt_out = r_out;
      OP_LOAD:   w_nxt_out = in;
      OP_INCR: begin
        w_nxt_out  = fit(w_inc_x);
        w_nxt_wrap = oob(w_inc_x);
      end
      OP_DECR: begin
        w_nxt_out  = fit(w_dec_x);
        w_nxt_wrap = oob(w_dec_x);
      end
      OP_ADDREL: begin
        w_nxt_out  = fit(w_rel_x);
        w_nxt_wrap = oob(w_rel_x);
      end
      OP_CLEAR:  w_nxt_out = '0;
      OP_CALL: begin
        // The jump happens even if the push is dropped on a full stack.
        w_nxt_out = in;
        if (w_full) w_set_err = 1'b1;
        else        w_push    = 1'b1;
      end
      OP_RET: begin
        if (w_empty) begin
          w_set_err = 1'b1;
        end else begin
          w_pop     = 1'b1;
          w_nxt_out = r_stack[w_pop_idx];
        end
      end
      default:   w_nxt_out = r_out;
    endcase
  end

  // Register value, wrap flag, stack depth and sticky error.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_out   <= RESET_VAL;
      r_wrap  <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_out  <= w_nxt_out;
      r_wrap <= w_nxt_wrap;
      if (w_push)     r_count <= r_count + CW'(1);
      else if (w_pop) r_count <= r_count - CW'(1);
      if (w_set_err)  r_err   <= 1'b1;
    end
  end

  // Stack storage needs no reset. Only entries below r_count are ever read as valid.
  always_ff @(negedge clk) begin
    if (!rst && w_push) r_stack[w_push_idx] <= w_ret_addr;
  end

  assign out       = r_out;
  assign wrap      = r_wrap;
  assign stk_count = r_count;
  assign stk_full  = w_full;
  assign stk_empty = w_empty;
  assign stk_err   = r_err;

endmodule
